// File: rtl/snake_video_ctrl.sv
// Snake video front end: pixel-enable divider, 640x480 VGA timing and game-state FSM.
// Optional build macro VGA_BORDER_EN draws a white frame around the visible area.
//
// state    | meaning
// ST_IDLE  | waiting for 'S'; snake held at start position, screen blanked
// ST_RUN   | game running
// ST_PAUSE | movement frozen by 'P', picture still shown
// ST_DEAD  | snake died; only Esc leaves
module snake_video_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_TOTAL   = 800,
    parameter int HS_START  = 656,
    parameter int HS_END    = 752,
    parameter int V_VISIBLE = 480,
    parameter int V_TOTAL   = 525,
    parameter int VS_START  = 490,
    parameter int VS_END    = 492
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        died,
    input  logic [7:0]  key_code,
    input  logic [11:0] rgb,
    output logic        pix_en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [3:0]  red_out,
    output logic [3:0]  green_out,
    output logic [3:0]  blue_out,
    output logic        hSync,
    output logic        vSync,
    output logic        init_snake,
    output logic        screen_black,
    output logic        screen_pause
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [7:0] KEY_S   = 8'h1B;
    localparam logic [7:0] KEY_P   = 8'h4D;
    localparam logic [7:0] KEY_ESC = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DEAD
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [11:0]   colour_q, colour_d;
    state_t        state_q, state_d;

    logic          in_visible;
    logic          on_border;

    assign pix_en = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (pix_en) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == 10'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y_q == 10'(V_TOTAL - 1)) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Sync and colour are sampled from the pre-increment position, so they lag x/y by one tick.
    always_comb begin
        in_visible = (x_q < 10'(H_VISIBLE)) && (y_q < 10'(V_VISIBLE));
`ifdef VGA_BORDER_EN
        on_border = (x_q == 10'd0) || (x_q == 10'(H_VISIBLE - 1)) ||
                    (y_q == 10'd0) || (y_q == 10'(V_VISIBLE - 1));
`else
        on_border = 1'b0;
`endif
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        colour_d = colour_q;
        if (pix_en) begin
            hsync_d = !((x_q >= 10'(HS_START)) && (x_q < 10'(HS_END)));
            vsync_d = !((y_q >= 10'(VS_START)) && (y_q < 10'(VS_END)));
            if (!in_visible || screen_black) begin
                colour_d = '0;
            end else if (on_border) begin
                colour_d = 12'hFFF;
            end else begin
                colour_d = rgb;
            end
        end
    end

    // Key codes are sticky levels, so transitions only fire on codes that matter in each state.
    always_comb begin
        state_d      = state_q;
        init_snake   = 1'b0;
        screen_black = 1'b0;
        screen_pause = 1'b0;
        case (state_q)
            ST_IDLE: begin
                init_snake   = 1'b1;
                screen_black = 1'b1;
                screen_pause = 1'b1;
                if (key_code == KEY_S) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (key_code == KEY_ESC) begin
                    state_d = ST_IDLE;
                end else if (died) begin
                    state_d = ST_DEAD;
                end else if (key_code == KEY_P) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                screen_pause = 1'b1;
                if (key_code == KEY_ESC) begin
                    state_d = ST_IDLE;
                end else if (key_code == KEY_S) begin
                    state_d = ST_RUN;
                end
            end
            ST_DEAD: begin
                screen_pause = 1'b1;
                if (key_code == KEY_ESC) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            colour_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            colour_q <= colour_d;
            state_q  <= state_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hSync     = hsync_q;
    assign vSync     = vsync_q;
    assign red_out   = colour_q[11:8];
    assign green_out = colour_q[7:4];
    assign blue_out  = colour_q[3:0];

endmodule

// File: tb/tb_snake_video_ctrl.sv
// Directed bench for snake_video_ctrl; vertical timing is shortened so a whole frame fits in a short run.
module tb_snake_video_ctrl;

    localparam int CLK_DIV = 4;
    localparam int VV      = 3;
    localparam int VT      = 7;
    localparam int VSS     = 4;
    localparam int VSE     = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        died = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [11:0] rgb = 12'h000;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  red_out;
    logic [3:0]  green_out;
    logic [3:0]  blue_out;
    logic        hSync;
    logic        vSync;
    logic        init_snake;
    logic        screen_black;
    logic        screen_pause;

    int checks = 0;
    int errors = 0;

    int   lows, first_x, first_y, prev_x, prev_y, wrap_ok, y_at_wrap;
    logic prev_s;

    snake_video_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .V_VISIBLE(VV),
        .V_TOTAL  (VT),
        .VS_START (VSS),
        .VS_END   (VSE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .died        (died),
        .key_code    (key_code),
        .rgb         (rgb),
        .pix_en      (pix_en),
        .x           (x),
        .y           (y),
        .red_out     (red_out),
        .green_out   (green_out),
        .blue_out    (blue_out),
        .hSync       (hSync),
        .vSync       (vSync),
        .init_snake  (init_snake),
        .screen_black(screen_black),
        .screen_pause(screen_pause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic align;
        int n;
        n = 0;
        @(negedge clk);
        while (!pix_en && n < 2 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        chk("align_pix_en", int'(pix_en), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xy(input int tx, input int ty, input int budget, input string tag);
        int n;
        n = 0;
        while (!(int'(x) == tx && (ty < 0 || int'(y) == ty)) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (int'(x) == tx && (ty < 0 || int'(y) == ty)) ? 1 : 0, 1);
    endtask

    task automatic fsm_step(input logic [7:0] k, input logic d,
                            input int ei, input int eb, input int ep, input string tag);
        @(negedge clk);
        key_code = k;
        died     = d;
        @(posedge clk);
        #1;
        chk({tag, "_init"},  int'(init_snake),   ei);
        chk({tag, "_black"}, int'(screen_black), eb);
        chk({tag, "_pause"}, int'(screen_pause), ep);
    endtask

    task automatic chk_colour(input string tag, input int er, input int eg, input int eb);
        chk({tag, "_r"}, int'(red_out),   er);
        chk({tag, "_g"}, int'(green_out), eg);
        chk({tag, "_b"}, int'(blue_out),  eb);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_hsync", int'(hSync), 1);
        chk("rst_vsync", int'(vSync), 1);
        chk_colour("rst_col", 0, 0, 0);
        chk("rst_init", int'(init_snake), 1);
        chk("rst_black", int'(screen_black), 1);
        chk("rst_pause", int'(screen_pause), 1);

        // Divider: pix_en before edges 4, 8, 12, 16
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("pix_en_edge%0d", k), int'(pix_en), (k % 4 == 0) ? 1 : 0);
            @(negedge clk);
        end
        chk("x_after_4_ticks", int'(x), 4);
        chk("y_after_4_ticks", int'(y), 0);
        chk("hsync_early", int'(hSync), 1);
        chk("vsync_early", int'(vSync), 1);

        // One full line of horizontal timing
        align();
        chk("x_aligned", int'(x), 5);
        lows = 0; first_x = -1; wrap_ok = 0; y_at_wrap = -1;
        prev_s = hSync;
        for (int i = 0; i < 800; i++) begin
            prev_x = int'(x);
            tick();
            if (!hSync) lows++;
            if (!hSync && prev_s && first_x < 0) first_x = int'(x);
            if (int'(x) == 0 && prev_x == 799) begin
                wrap_ok   = 1;
                y_at_wrap = int'(y);
            end
            prev_s = hSync;
        end
        chk("hsync_low_ticks", lows, 96);
        chk("hsync_first_low_x", first_x, 657);
        chk("x_wrap_from_799", wrap_ok, 1);
        chk("y_at_x_wrap", y_at_wrap, 1);
        chk("x_after_line", int'(x), 5);
        chk("y_after_line", int'(y), 1);

        // Game-state FSM
        fsm_step(8'h75, 1'b0, 1, 1, 1, "idle_arrow");
        fsm_step(8'h00, 1'b1, 1, 1, 1, "idle_died");
        @(negedge clk);
        key_code = 8'h1B;
        died     = 1'b0;
        #1;
        chk("idle_s_same_clk_init", int'(init_snake), 1);
        @(posedge clk);
        #1;
        chk("run_init",  int'(init_snake),   0);
        chk("run_black", int'(screen_black), 0);
        chk("run_pause", int'(screen_pause), 0);
        fsm_step(8'h1B, 1'b0, 0, 0, 0, "run_hold_s");
        fsm_step(8'h4D, 1'b0, 0, 0, 1, "pause");
        fsm_step(8'h4D, 1'b1, 0, 0, 1, "pause_died");
        fsm_step(8'h1B, 1'b0, 0, 0, 0, "resume");
        fsm_step(8'h1B, 1'b1, 0, 0, 1, "dead");
        fsm_step(8'h1B, 1'b0, 0, 0, 1, "dead_s_ignored");
        fsm_step(8'h76, 1'b0, 1, 1, 1, "dead_esc");
        fsm_step(8'h1B, 1'b0, 0, 0, 0, "run2");
        fsm_step(8'h76, 1'b1, 1, 1, 1, "esc_and_died");
        fsm_step(8'h4D, 1'b0, 1, 1, 1, "idle_p");
        fsm_step(8'h1B, 1'b0, 0, 0, 0, "run3");

        // Colour path, line y=1 in RUN
        rgb = 12'hF00;
        align();
        wait_xy(100, 1, 1000, "reach_x100_y1");
        tick();
        chk_colour("col_x100", 15, 0, 0);
        wait_xy(639, 1, 1000, "reach_x639_y1");
        tick();
        chk_colour("col_x639", 15, 0, 0);
        tick();
        chk_colour("col_x640", 0, 0, 0);
        wait_xy(700, 1, 1000, "reach_x700_y1");
        tick();
        chk_colour("col_x700", 0, 0, 0);

        // Blanked in IDLE, then a different colour back in RUN
        fsm_step(8'h76, 1'b0, 1, 1, 1, "col_idle");
        align();
        wait_xy(100, 2, 1000, "reach_x100_y2");
        tick();
        chk_colour("col_black", 0, 0, 0);
        rgb = 12'h3C5;
        fsm_step(8'h1B, 1'b0, 0, 0, 0, "col_run");
        align();
        wait_xy(300, 2, 1000, "reach_x300_y2");
        tick();
        chk_colour("col_last_line", 3, 12, 5);
        wait_xy(100, 3, 1000, "reach_x100_y3");
        tick();
        chk_colour("col_below_visible", 0, 0, 0);

        // One full frame of vertical timing
        lows = 0; first_x = -1; first_y = -1; wrap_ok = 0;
        prev_s = vSync;
        for (int i = 0; i < 800 * VT; i++) begin
            prev_y = int'(y);
            tick();
            if (!vSync) lows++;
            if (!vSync && prev_s && first_x < 0) begin
                first_x = int'(x);
                first_y = int'(y);
            end
            if (int'(y) == 0 && prev_y == VT - 1 && int'(x) == 0) wrap_ok = 1;
            prev_s = vSync;
        end
        chk("vsync_low_ticks", lows, 1600);
        chk("vsync_first_low_x", first_x, 1);
        chk("vsync_first_low_y", first_y, VSS);
        chk("y_wrap_from_last", wrap_ok, 1);
        chk("x_after_frame", int'(x), 101);
        chk("y_after_frame", int'(y), 3);

        // Asynchronous reset mid-line
        wait_xy(300, -1, 1000, "reach_x300");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_pix_en", int'(pix_en), 0);
        chk("midrst_hsync", int'(hSync), 1);
        chk("midrst_init", int'(init_snake), 1);
        chk("midrst_black", int'(screen_black), 1);
        chk("midrst_pause", int'(screen_pause), 1);
        chk_colour("midrst_col", 0, 0, 0);
        #20;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_video_ctrl.md
Name: snake_video_ctrl

Overview:
Video and game-control front end of the snake design, in a single `clk` domain. It has three parts:
- a divide-by-4 pixel-enable generator (25 MHz tick from 100 MHz `clk`);
- a 640x480@60 VGA timing generator that outputs the current pixel coordinate and registered 4:4:4 colour/sync;
- a Moore game-state FSM that tells the snake logic when to initialise, freeze or blank the screen.

Parameters:
CLK_DIV, 4, clk cycles per pixel tick (>=2)
H_VISIBLE, 640, visible pixels per line
H_TOTAL, 800, pixel ticks per line
HS_START, 656, first pixel tick with hSync asserted (low)
HS_END, 752, first pixel tick after hSync pulse
V_VISIBLE, 480, visible lines
V_TOTAL, 525, lines per frame
VS_START, 490, first line with vSync low
VS_END, 492, first line after vSync pulse

Ports:
clk  in  1  system clock, 100 MHz, rising edge
rst_n  in  1  asynchronous active-low reset
died  in  1  snake death indication, level
key_code  in  8  last PS/2 make code pressed, level (sticky)
rgb  in  12  pixel colour {R[11:8],G[7:4],B[3:0]} for current x/y
pix_en  out  1  one-clk-wide pixel tick
x  out  10  current horizontal counter 0..H_TOTAL-1
y  out  10  current vertical counter 0..V_TOTAL-1
red_out  out  4  VGA red
green_out  out  4  VGA green
blue_out  out  4  VGA blue
hSync  out  1  horizontal sync, active low
vSync  out  1  vertical sync, active low
init_snake  out  1  1 = snake logic loads initial position
screen_black  out  1  1 = all colour forced to 0
screen_pause  out  1  1 = snake movement frozen

Behaviour:
- Reset (async, rst_n=0):
  - divider count, x and y clear to 0; pix_en=0.
  - hSync=1, vSync=1, colour outputs 0.
  - FSM enters IDLE.
- Divider:
  - count runs 0..CLK_DIV-1 and wraps.
  - pix_en=1 exactly when count==CLK_DIV-1.
  - After reset release, the first pix_en is on the 4th clk edge; then every 4 clks.
- Counters advance only on pix_en.
  - x wraps H_TOTAL-1 -> 0.
  - y increments only when x wraps; y wraps V_TOTAL-1 -> 0 on the same tick that x wraps.
- Registered outputs, updated on each pix_en from the pre-increment x/y (one pixel tick of latency relative to x/y):
  - hSync = !(HS_START <= x < HS_END).
  - vSync = !(VS_START <= y < VS_END).
  - colour = rgb when x < H_VISIBLE, y < V_VISIBLE and screen_black=0; otherwise 0.
- FSM states, in priority order within each state:
  - IDLE (reset state): outputs init=1, black=1, pause=1.
    - key_code==8'h1B ('S') -> RUN.
  - RUN: outputs init=0, black=0, pause=0.
    - key_code==8'h76 (Esc) -> IDLE.
    - else died=1 -> DEAD.
    - else key_code==8'h4D ('P') -> PAUSE.
  - PAUSE: outputs init=0, black=0, pause=1.
    - Esc -> IDLE.
    - else 'S' -> RUN.
  - DEAD: outputs init=0, black=0, pause=1.
    - Esc -> IDLE only; 'S' is ignored.
- FSM rules:
  - Evaluates every clk, not gated by pix_en.
  - Outputs are decoded from the state register, so they change one clk after the causing input.
  - Because key_code is sticky, actions are level based: a held 'S' in RUN does nothing; an arrow code in any state does nothing.
  - died outside RUN is ignored.
- Reset mid-frame: counters restart at 0,0 asynchronously, with no partial-line completion.

Optional Feature:
VGA_BORDER_EN:
- When defined: visible pixels with x==0, x==639, y==0 or y==479 output 12'hFFF, overriding rgb, unless screen_black=1.
- When undefined: no border; colour follows rgb only.

Test Plan:
- Reset, then 16 clks -> pix_en high at clk 4,8,12,16; x=4 after 4 ticks; hSync=1, vSync=1.
- Run 800 pixel ticks -> hSync low for exactly 96 ticks; first low sample follows x=656; x wraps to 0, y=1.
- Run one full frame (420000 pix_en) -> vSync low for 2 lines (1600 ticks) starting after y=490; y wraps 524->0.
- rgb=12'hF00 held, FSM in RUN -> colour F/0/0 for x<640,y<480; 0 at x=700; 0 at y=500.
- key_code 8'h1B -> RUN (init=0, black=0, pause=0); 8'h4D -> PAUSE (pause=1); 8'h1B -> RUN; died=1 -> DEAD; 8'h1B -> stays DEAD; 8'h76 -> IDLE (init=1, black=1).
- In RUN, apply Esc and died in the same clk -> IDLE. Assert rst_n=0 mid-line at x=300 -> x=0, y=0, FSM IDLE immediately.
